// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: state encoding, ordered-set type codes and
// consecutive-OS thresholds used by both the receive and transmit halves.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DetectQuiet                 = 4'b0000,
    DetectActive                = 4'b0001,
    PollingActive               = 4'b0010,
    PollingConfigration         = 4'b0011,
    ConfigrationLinkWidthStart  = 4'b0100,
    ConfigrationLinkWidthAccept = 4'b0101,
    ConfigrationLaneNumWait     = 4'b0110,
    ConfigrationLaneNumActive   = 4'b0111,
    ConfigrationComplete        = 4'b1000,
    ConfigrationIdle            = 4'b1001,
    L0                          = 4'b1010,
    Idle                        = 4'b1111
  } ltssmState_t;

  typedef enum logic [1:0] {
    OsTs1   = 2'b00,
    OsTs2   = 2'b01,
    OsIdle  = 2'b10,
    OsOther = 2'b11
  } osType_t;

  // Consecutive qualifying ordered sets needed before a receive exit.
  localparam logic [3:0] THRESH_LONG  = 4'd8;
  localparam logic [3:0] THRESH_SHORT = 4'd2;

  // Polling and Configration states run the receive timeout timer.
  function automatic logic isTimedState(input logic [3:0] s);
    return (s >= PollingActive) && (s <= ConfigrationIdle);
  endfunction

endpackage

// File: rtl/os_consecutive_counter.sv
// Consecutive ordered-set counter: holds the run length, the upstream link
// number candidate and the per-state done flag.
module os_consecutive_counter (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       zero,
  input  logic       inc,
  input  logic       reload,
  input  logic [7:0] reloadVal,
  input  logic       setDone,
  output logic [2:0] count,
  output logic [7:0] cand,
  output logic       done
);

  // Clear wins over everything; a reload restarts the run at one with a new candidate.
  always_ff @(posedge Pclk) begin
    if (!Reset || clear) begin
      count <= '0;
      cand  <= '0;
      done  <= 1'b0;
    end else begin
      if (setDone) begin
        done <= 1'b1;
      end
      if (reload) begin
        cand  <= reloadVal;
        count <= 3'd1;
      end else if (zero) begin
        count <= '0;
      end else if (inc && (count != 3'd7)) begin
        count <= count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/rx_ltssm.sv
// Receive-side LTSSM: qualifies decoded ordered sets against the current
// state's exit rule, captures the link number on upstream devices and
// enforces the per-state receive timeout.
//
// Handshake: the main LTSSM holds SetRXState at the state it is in; any
// change restarts qualification. RXFinishFlag is a single-cycle pulse and
// RXExitTo is only meaningful in that cycle (it holds its last value
// otherwise). After a pulse nothing more is reported until SetRXState changes.
module rx_ltssm
  import ltssm_pkg::*;
#(
  parameter int          DEVICETYPE     = 0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6_000_000
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [3:0] SetRXState,
  output logic       RXFinishFlag,
  output logic [3:0] RXExitTo,
  input  logic       OSValid,
  input  logic [1:0] OSType,
  input  logic [7:0] RxLinkNum,
  input  logic       RxLinkPad,
  input  logic       RxLanePad,
  input  logic [7:0] ReadLinkNum,
  output logic [7:0] WriteLinkNum,
  output logic       WriteLinkNumFlag
);

  localparam bit IS_UPSTREAM = (DEVICETYPE == 1);

  ltssmState_t State;
  logic [23:0] timer;

  logic        stateChange;
  logic        active;
  logic        isTs;
  logic        isTs1;
  logic        isTs2;
  logic        linkMatch;
  logic        qual;
  logic        reloadCand;
  logic        hasRule;
  logic [3:0]  thresh;
  ltssmState_t ruleExit;
  logic        osEvent;
  logic        cntZero;
  logic        cntInc;
  logic        cntReload;
  logic        thresholdHit;
  logic        timeoutHit;
  logic        writeHit;

  logic [2:0]  count;
  logic [7:0]  cand;
  logic        cntDone;

  os_consecutive_counter uCounter (
    .Pclk      (Pclk),
    .Reset     (Reset),
    .clear     (stateChange),
    .zero      (cntZero),
    .inc       (cntInc),
    .reload    (cntReload),
    .reloadVal (RxLinkNum),
    .setDone   (thresholdHit || timeoutHit),
    .count     (count),
    .cand      (cand),
    .done      (cntDone)
  );

  // Per-state qualifier, threshold detection and timeout detection.
  always_comb begin
    stateChange = (SetRXState != State);
    active      = !stateChange && !cntDone;
    isTs1       = (OSType == OsTs1);
    isTs2       = (OSType == OsTs2);
    isTs        = isTs1 || isTs2;
    linkMatch   = !RxLinkPad && (RxLinkNum == ReadLinkNum);
    qual        = 1'b0;
    reloadCand  = 1'b0;
    hasRule     = 1'b1;
    thresh      = THRESH_LONG;
    ruleExit    = DetectQuiet;
    case (State)
      PollingActive: begin
        qual     = isTs && RxLinkPad && RxLanePad;
        ruleExit = PollingConfigration;
      end
      PollingConfigration: begin
        qual     = isTs2 && RxLinkPad && RxLanePad;
        ruleExit = ConfigrationLinkWidthStart;
      end
      ConfigrationLinkWidthStart: begin
        thresh   = THRESH_SHORT;
        ruleExit = ConfigrationLinkWidthAccept;
        if (IS_UPSTREAM) begin
          // A new link number restarts the run with that number as candidate.
          qual       = isTs1 && !RxLinkPad && RxLanePad;
          reloadCand = qual && (RxLinkNum != cand);
        end else begin
          qual = isTs1 && linkMatch && RxLanePad;
        end
      end
      ConfigrationLinkWidthAccept: begin
        thresh   = THRESH_SHORT;
        qual     = isTs1 && linkMatch && !RxLanePad;
        ruleExit = ConfigrationLaneNumWait;
      end
      ConfigrationLaneNumWait: begin
        thresh   = THRESH_SHORT;
        qual     = isTs1 && linkMatch && !RxLanePad;
        ruleExit = ConfigrationLaneNumActive;
      end
      ConfigrationLaneNumActive: begin
        thresh   = THRESH_SHORT;
        qual     = isTs && linkMatch && !RxLanePad;
        ruleExit = ConfigrationComplete;
      end
      ConfigrationComplete: begin
        qual     = isTs2 && linkMatch;
        ruleExit = ConfigrationIdle;
      end
      ConfigrationIdle: begin
        qual     = (OSType == OsIdle);
        ruleExit = L0;
      end
      default: hasRule = 1'b0;
    endcase
    osEvent      = OSValid && active && hasRule;
    cntReload    = osEvent && reloadCand;
    cntInc       = osEvent && qual && !reloadCand;
    cntZero      = osEvent && !qual;
    thresholdHit = cntInc && (({1'b0, count} + 4'd1) == thresh);
    timeoutHit   = isTimedState(State) && active && (timer == TIMEOUT_CYCLES - 24'd1);
    writeHit     = IS_UPSTREAM && thresholdHit && (State == ConfigrationLinkWidthStart);
  end

  // State tracking, timeout timer and registered exit/link-number outputs.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      State            <= Idle;
      timer            <= '0;
      RXFinishFlag     <= 1'b0;
      RXExitTo         <= DetectQuiet;
      WriteLinkNum     <= '0;
      WriteLinkNumFlag <= 1'b0;
    end else begin
      State <= ltssmState_t'(SetRXState);
      if (stateChange || !isTimedState(State)) begin
        timer <= '0;
      end else if (!cntDone) begin
        timer <= timer + 24'd1;
      end
      RXFinishFlag <= thresholdHit || timeoutHit;
      // Threshold exit takes priority over a coincident timeout.
      if (thresholdHit) begin
        RXExitTo <= ruleExit;
      end else if (timeoutHit) begin
        RXExitTo <= DetectQuiet;
      end
      WriteLinkNumFlag <= writeHit;
      if (writeHit) begin
        WriteLinkNum <= cand;
      end
    end
  end

endmodule
